// File: rtl/perceptron_pkg.sv
// Shared types and constants for the perceptron scheduler and its clients.
package perceptron_pkg;

  localparam logic [1:0] CLASS_NOTHING = 2'd0;
  localparam logic [1:0] CLASS_CIRCLE  = 2'd1;
  localparam logic [1:0] CLASS_CROSS   = 2'd2;
  localparam logic [1:0] CLASS_NA      = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } sched_state_t;

  localparam logic [24:0] CIRCLE_PAT = 25'h0454544;
  localparam logic [24:0] CROSS_PAT  = 25'h1151151;

endpackage

// File: rtl/perceptron_sched_rr_arbiter.sv
// Combinational round-robin pick: first set req bit after ptr, wrapping around.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          valid
);

  logic [IW-1:0] pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    pos   = '0;
    for (int unsigned off = 1; off <= N; off++) begin
      pos = IW'((32'(ptr) + off) % N);
      if (!valid && req[pos]) begin
        grant[pos] = 1'b1;
        idx        = pos;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/perceptron_sched.sv
// Shares one perceptron between N_REQ requesters: round-robin grant, guarded
// wait for a fresh ready (min wait + timeout), and one-hot result return.
module perceptron_sched
  import perceptron_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned WIDTH    = 25,
  parameter int unsigned MIN_WAIT = 6,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [1:0]             rsp_class,
  output logic                   rsp_err,
  output logic                   busy,
  output logic                   p_en,
  output logic [WIDTH-1:0]       p_in,
  input  logic                   p_ready,
  input  logic [1:0]             p_out
);

  localparam int unsigned IW = $clog2(N_REQ);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  sched_state_t state, state_next;

  logic [IW-1:0]    ptr, ptr_d, cur_idx, idx_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic [N_REQ-1:0] arb_grant;
  logic [IW-1:0]    arb_idx;
  logic             arb_valid;

  logic [N_REQ-1:0] gnt_d, rsp_valid_d;
  logic [1:0]       rsp_class_d;
  logic             rsp_err_d, busy_d, p_en_d;
  logic [WIDTH-1:0] p_in_d;

  logic ready_ok, timed_out;

  rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
    .req   (req),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  // Ready is only trusted after MIN_WAIT cycles so a level left over from the
  // previous job cannot complete this one.
  assign ready_ok  = p_ready && (cnt >= CW'(MIN_WAIT));
  assign timed_out = (cnt == CW'(TIMEOUT - 1));

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (arb_valid) state_next = S_RUN;
      S_RUN:   if (ready_ok || timed_out) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Computes next values for the registered outputs from the current state.
  always_comb begin
    gnt_d       = '0;
    rsp_valid_d = '0;
    rsp_class_d = rsp_class;
    rsp_err_d   = rsp_err;
    p_in_d      = p_in;
    ptr_d       = ptr;
    idx_d       = cur_idx;
    cnt_d       = cnt;
    p_en_d      = (state_next == S_RUN);
    busy_d      = (state_next != S_IDLE);
    case (state)
      S_IDLE: begin
        if (arb_valid) begin
          gnt_d  = arb_grant;
          p_in_d = req_data[arb_idx*WIDTH +: WIDTH];
          ptr_d  = arb_idx;
          idx_d  = arb_idx;
          cnt_d  = '0;
        end
      end
      S_RUN: begin
        cnt_d = cnt + CW'(1);
        if (ready_ok) begin
          rsp_class_d          = p_out;
          rsp_err_d            = 1'b0;
          rsp_valid_d[cur_idx] = 1'b1;
        end else if (timed_out) begin
          rsp_class_d          = CLASS_NA;
          rsp_err_d            = 1'b1;
          rsp_valid_d[cur_idx] = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ptr       <= IW'(N_REQ - 1);
      cur_idx   <= '0;
      cnt       <= '0;
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_class <= CLASS_NOTHING;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      p_en      <= 1'b0;
      p_in      <= '0;
    end else begin
      state     <= state_next;
      ptr       <= ptr_d;
      cur_idx   <= idx_d;
      cnt       <= cnt_d;
      gnt       <= gnt_d;
      rsp_valid <= rsp_valid_d;
      rsp_class <= rsp_class_d;
      rsp_err   <= rsp_err_d;
      busy      <= busy_d;
      p_en      <= p_en_d;
      p_in      <= p_in_d;
    end
  end

endmodule

// File: tb/tb_perceptron_sched.sv
// Directed bench for perceptron_sched with a behavioural perceptron model
// (programmable ready latency, stuck-high and stuck-low ready modes).
module tb_perceptron_sched;
  import perceptron_pkg::*;

  localparam int N = 4;
  localparam int W = 25;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   gnt, rsp_valid;
  logic [1:0]     rsp_class;
  logic           rsp_err, busy, p_en;
  logic [W-1:0]   p_in;
  logic           p_ready;
  logic [1:0]     p_out;

  int tests = 0;
  int fails = 0;

  // perceptron model: mode 0 = ready m_lat cycles after p_en rises,
  // mode 1 = ready stuck high, mode 2 = ready stuck low
  int         m_mode = 0;
  int         m_lat = 10;
  logic [1:0] m_out = 2'd0;
  int         m_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!p_en) m_cnt <= 0;
    else       m_cnt <= m_cnt + 1;
  end

  assign p_ready = (m_mode == 1) || (m_mode == 0 && p_en && m_cnt >= m_lat);
  assign p_out   = m_out;

  perceptron_sched #(
    .N_REQ(N), .WIDTH(W), .MIN_WAIT(6), .TIMEOUT(255)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_class(rsp_class), .rsp_err(rsp_err),
    .busy(busy), .p_en(p_en), .p_in(p_in), .p_ready(p_ready), .p_out(p_out)
  );

  task automatic wait_gnt(input int bound, output int n);
    n = 0;
    while (n < bound) begin
      @(negedge clk);
      n++;
      if (gnt != '0) break;
    end
  endtask

  // counts anomalies while a job runs: stray gnt, p_en low, p_in changing
  task automatic wait_rsp(input int bound, output int n, output int bad);
    logic [W-1:0] held;
    held = p_in;
    n = 0;
    bad = 0;
    while (n < bound) begin
      @(negedge clk);
      n++;
      if (rsp_valid != '0) break;
      if (gnt != '0 || p_en !== 1'b1 || p_in !== held) bad++;
    end
  endtask

  task automatic do_reset();
    req = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++; if ({gnt, rsp_valid, rsp_class, rsp_err, busy, p_en} !== 13'd0) begin fails++; $display("FAIL reset_outs: got %h expected 0", {gnt, rsp_valid, rsp_class, rsp_err, busy, p_en}); end
    tests++; if (p_in !== '0) begin fails++; $display("FAIL reset_p_in: got %h expected 0", p_in); end
    req = '1;
    repeat (2) @(negedge clk);
    tests++; if (gnt !== '0 || p_en !== 1'b0) begin fails++; $display("FAIL reset_hold: gnt %b p_en %b expected 0 0", gnt, p_en); end
    req = '0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int n, bad;
    m_mode = 0; m_lat = 10; m_out = CLASS_CIRCLE;
    req_data[0 +: W] = CIRCLE_PAT;
    req = 4'b0001;
    wait_gnt(20, n);
    req = '0;
    tests++; if (gnt !== 4'b0001) begin fails++; $display("FAIL single_gnt: got %b expected 0001", gnt); end
    tests++; if (n !== 1) begin fails++; $display("FAIL single_gnt_lat: got %0d expected 1", n); end
    tests++; if (p_en !== 1'b1 || p_in !== CIRCLE_PAT) begin fails++; $display("FAIL single_drive: p_en %b p_in %h expected 1 %h", p_en, p_in, CIRCLE_PAT); end
    wait_rsp(300, n, bad);
    tests++; if (bad !== 0) begin fails++; $display("FAIL single_hold: got %0d anomalies expected 0", bad); end
    tests++; if (n !== 11) begin fails++; $display("FAIL single_rsp_lat: got %0d expected 11", n); end
    tests++; if (rsp_valid !== 4'b0001) begin fails++; $display("FAIL single_rsp_valid: got %b expected 0001", rsp_valid); end
    tests++; if (rsp_class !== CLASS_CIRCLE || rsp_err !== 1'b0) begin fails++; $display("FAIL single_result: class %0d err %b expected 1 0", rsp_class, rsp_err); end
    tests++; if (p_en !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL single_done: p_en %b busy %b expected 0 1", p_en, busy); end
    @(negedge clk);
    tests++; if (rsp_valid !== '0 || p_en !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL single_idle: rsp_valid %b p_en %b busy %b expected 0 0 0", rsp_valid, p_en, busy); end
    tests++; if (rsp_class !== CLASS_CIRCLE) begin fails++; $display("FAIL single_class_hold: got %0d expected 1", rsp_class); end
  endtask

  task automatic test_contention();
    int n, bad;
    int ord [5] = '{0, 1, 2, 3, 0};
    logic [W-1:0] pat [N];
    do_reset();
    m_mode = 0; m_lat = 10; m_out = CLASS_CROSS;
    for (int i = 0; i < N; i++) begin
      pat[i] = CROSS_PAT ^ W'(32'h10 << i);
      req_data[i*W +: W] = pat[i];
    end
    req = '1;
    for (int j = 0; j < 5; j++) begin
      wait_gnt(10, n);
      if (j > 0) begin
        tests++; if (n !== 2) begin fails++; $display("FAIL cont_gap%0d: got %0d expected 2", j, n); end
      end
      tests++; if (gnt !== (4'b0001 << ord[j])) begin fails++; $display("FAIL cont_gnt%0d: got %b expected %b", j, gnt, 4'b0001 << ord[j]); end
      tests++; if (p_in !== pat[ord[j]]) begin fails++; $display("FAIL cont_p_in%0d: got %h expected %h", j, p_in, pat[ord[j]]); end
      wait_rsp(300, n, bad);
      if (j == 4) req = '0;
      tests++; if (rsp_valid !== (4'b0001 << ord[j]) || bad !== 0) begin fails++; $display("FAIL cont_rsp%0d: rsp_valid %b anomalies %0d expected %b 0", j, rsp_valid, bad, 4'b0001 << ord[j]); end
      tests++; if (rsp_class !== CLASS_CROSS) begin fails++; $display("FAIL cont_class%0d: got %0d expected 2", j, rsp_class); end
    end
    @(negedge clk);
  endtask

  task automatic test_stale_ready();
    int n, bad;
    m_mode = 1; m_out = CLASS_CROSS;
    req_data[2*W +: W] = CIRCLE_PAT;
    req = 4'b0100;
    wait_gnt(10, n);
    req = '0;
    tests++; if (gnt !== 4'b0100) begin fails++; $display("FAIL stale_gnt: got %b expected 0100", gnt); end
    wait_rsp(300, n, bad);
    tests++; if (n !== 7) begin fails++; $display("FAIL stale_lat: got %0d expected 7", n); end
    tests++; if (rsp_valid !== 4'b0100 || rsp_class !== CLASS_CROSS || rsp_err !== 1'b0) begin fails++; $display("FAIL stale_result: rsp_valid %b class %0d err %b expected 0100 2 0", rsp_valid, rsp_class, rsp_err); end
    m_mode = 0;
  endtask

  task automatic test_timeout();
    int n, bad;
    m_mode = 2;
    req_data[3*W +: W] = CROSS_PAT;
    req = 4'b1000;
    wait_gnt(10, n);
    req = '0;
    tests++; if (gnt !== 4'b1000) begin fails++; $display("FAIL to_gnt: got %b expected 1000", gnt); end
    wait_rsp(400, n, bad);
    tests++; if (n !== 255) begin fails++; $display("FAIL to_lat: got %0d expected 255", n); end
    tests++; if (rsp_valid !== 4'b1000 || rsp_class !== CLASS_NA || rsp_err !== 1'b1) begin fails++; $display("FAIL to_result: rsp_valid %b class %0d err %b expected 1000 3 1", rsp_valid, rsp_class, rsp_err); end
    m_mode = 0; m_lat = 10; m_out = CLASS_CIRCLE;
    req_data[0 +: W] = CIRCLE_PAT;
    req = 4'b0001;
    wait_gnt(10, n);
    req = '0;
    tests++; if (gnt !== 4'b0001 || n !== 2) begin fails++; $display("FAIL to_next_gnt: gnt %b after %0d expected 0001 after 2", gnt, n); end
    wait_rsp(300, n, bad);
    tests++; if (n !== 11 || rsp_valid !== 4'b0001 || rsp_class !== CLASS_CIRCLE || rsp_err !== 1'b0) begin fails++; $display("FAIL to_next_rsp: lat %0d rsp_valid %b class %0d err %b expected 11 0001 1 0", n, rsp_valid, rsp_class, rsp_err); end
  endtask

  task automatic test_reset_mid_run();
    int n, bad;
    m_mode = 0; m_lat = 10; m_out = CLASS_CROSS;
    req = 4'b0100;
    wait_gnt(10, n);
    tests++; if (gnt !== 4'b0100) begin fails++; $display("FAIL mid_gnt: got %b expected 0100", gnt); end
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++; if (p_en !== 1'b0 || busy !== 1'b0 || rsp_valid !== '0) begin fails++; $display("FAIL mid_async: p_en %b busy %b rsp_valid %b expected 0 0 0", p_en, busy, rsp_valid); end
    req = 4'b0110;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_gnt(10, n);
    tests++; if (gnt !== 4'b0010 || n !== 1) begin fails++; $display("FAIL mid_regrant: gnt %b after %0d expected 0010 after 1", gnt, n); end
    wait_rsp(300, n, bad);
    tests++; if (rsp_valid !== 4'b0010 || bad !== 0) begin fails++; $display("FAIL mid_rsp1: rsp_valid %b anomalies %0d expected 0010 0", rsp_valid, bad); end
    wait_gnt(10, n);
    req = '0;
    tests++; if (gnt !== 4'b0100) begin fails++; $display("FAIL mid_gnt2: got %b expected 0100", gnt); end
    wait_rsp(300, n, bad);
    tests++; if (rsp_valid !== 4'b0100) begin fails++; $display("FAIL mid_rsp2: got %b expected 0100", rsp_valid); end
  endtask

  task automatic test_wrap();
    int n, bad;
    m_mode = 0; m_lat = 10; m_out = CLASS_CIRCLE;
    req = 4'b1000;
    wait_gnt(10, n);
    tests++; if (gnt !== 4'b1000) begin fails++; $display("FAIL wrap_gnt3: got %b expected 1000", gnt); end
    req = 4'b1010;
    wait_rsp(300, n, bad);
    wait_gnt(10, n);
    tests++; if (gnt !== 4'b0010) begin fails++; $display("FAIL wrap_gnt1: got %b expected 0010", gnt); end
    wait_rsp(300, n, bad);
    wait_gnt(10, n);
    req = '0;
    tests++; if (gnt !== 4'b1000) begin fails++; $display("FAIL wrap_gnt3b: got %b expected 1000", gnt); end
    wait_rsp(300, n, bad);
    tests++; if (rsp_valid !== 4'b1000 || rsp_class !== CLASS_CIRCLE) begin fails++; $display("FAIL wrap_rsp: rsp_valid %b class %0d expected 1000 1", rsp_valid, rsp_class); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_stale_ready();
    test_timeout();
    test_reset_mid_run();
    test_wrap();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
